voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have: ev_valid  in  1  note event present.
REQ-004 SHALL have: ev_ready  out  1  allocator can accept an event.
REQ-005 SHALL have: ev_on  in  1  event kind; 1 = note-on, 0 = note-off.
REQ-006 SHALL have: ev_note  in  7  MIDI note number of the event.
REQ-007 SHALL have: voice_done  in  4  per-voice done pulse from each envelope_generator.
REQ-008 SHALL have: note_on  out  4  per-voice one-cycle note_on pulse to each envelope_generator.
REQ-009 SHALL have: note_off  out  4  per-voice one-cycle note_off pulse.
REQ-010 SHALL have: voice_note  out  28  packed 7-bit note per voice; voice i at bits [7i+6:7i].
REQ-011 SHALL have: voice_active  out  4  voice is HELD or RELEASING.
REQ-012 SHALL have: stolen  out  1  one-cycle pulse when a held voice is force-released.
REQ-013 SHALL have: dropped  out  1  one-cycle pulse when an event is discarded.

Function
REQ-014 SHALL track each voice as FREE, HELD or RELEASING, plus a 2-bit age rank; ranks always form a permutation of 0..3, with 0 = newest.
REQ-015 SHALL run a controller FSM with states IDLE, DECIDE and WAIT_FREE; ev_ready = 1 only in IDLE.
REQ-016 IDLE: on an edge with ev_valid & ev_ready, SHALL register ev_on and ev_note and go to DECIDE; the minimum accept interval is 2 cycles.
REQ-017 SHALL define eff_free[i] = FREE[i] | (RELEASING[i] & voice_done[i]), evaluated in the same cycle.
REQ-018 DECIDE with note-off: SHALL target the lowest-index HELD voice whose voice_note equals the note; SHALL pulse note_off on that voice, set it RELEASING and return to IDLE.
REQ-019 DECIDE with note-off and no matching HELD voice: SHALL pulse dropped and return to IDLE.
REQ-020 DECIDE with note-on whose note is already HELD: SHALL pulse dropped, leave the voice unchanged and return to IDLE.
REQ-021 DECIDE with note-on and an eff_free voice: SHALL choose the lowest-index eff_free voice k, pulse note_on[k], load voice_note[k], set k HELD, apply the rank update and return to IDLE.
REQ-022 Rank update on allocating voice k (old rank r): every voice with rank < r SHALL increment; k SHALL get rank 0.
REQ-023 DECIDE with note-on, no eff_free voice and at least one RELEASING voice: SHALL go to WAIT_FREE with no pulse.
REQ-024 DECIDE with note-on, no eff_free voice and none RELEASING: SHALL pulse note_off and stolen on the HELD voice with the highest rank, set it RELEASING and go to WAIT_FREE.
REQ-025 WAIT_FREE: when any RELEASING voice sees voice_done, that voice SHALL become FREE and the FSM SHALL go to DECIDE, which re-evaluates the pending note-on.
REQ-026 voice_done on a RELEASING voice SHALL free it in any FSM state; voice_done on a FREE or HELD voice SHALL be ignored.
REQ-027 note_on, note_off, stolen and dropped SHALL be registered outputs, high for exactly the one cycle following the DECIDE edge that issued them.
REQ-028 At most one bit of note_on|note_off SHALL be set in any cycle.
REQ-029 Latency from the accept edge to a note_on pulse SHALL be 2 edges when a voice is free; pulses are visible in cycle T+2 for accept at edge T.
REQ-030 voice_note[i] SHALL hold its value while the voice is RELEASING and FREE.

Reset
REQ-031 When rst is high at an edge, the block SHALL enter IDLE and drop any pending event.
REQ-032 Reset SHALL set all voices FREE, rank[i] = i, and voice_note to 0.
REQ-033 After reset, note_on, note_off, stolen, dropped and voice_active SHALL be 0, and ev_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 rst SHALL take priority over ev_valid and voice_done in the same cycle.

Verification
REQ-035 Bench SHALL check: note-ons for 60, 62 and 64 after reset -> note_on pulses on voices 0, 1 and 2 at accept+2; voice_note = 60/62/64; voice_active = 0111.
REQ-036 Bench SHALL check: four note-ons 60/62/64/65 held, then note-on 67 -> note_off[0] and stolen pulse together; the block waits; voice_done[0] 10 cycles later -> note_on[0] with voice_note[0] = 67.
REQ-037 Bench SHALL check: note-off for 62 while held on voice 1 -> note_off[1] pulse; a later voice_done[1] clears voice_active[1]; a second note-off for 62 -> dropped pulse.
REQ-038 Bench SHALL check: all four voices RELEASING, a note-on arrives and voice_done[2] asserts in the DECIDE cycle -> voice 2 is allocated directly, with no WAIT_FREE and no stolen pulse.
REQ-039 Bench SHALL check: duplicate note-on 60 while 60 is held -> dropped pulse and no note_on.
REQ-040 Bench SHALL check: rst asserted during WAIT_FREE -> the next cycle shows ev_ready = 1, voice_active = 0000 and no pulses; the pending note is lost.

Source files
------------

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - four-voice note allocator with oldest-held stealing
// Tracks voice state and age rank, turning note events into per-voice note_on/note_off pulses.
module voice_allocator (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic        ev_on,
    input  logic [6:0]  ev_note,
    input  logic [3:0]  voice_done,
    output logic [3:0]  note_on,
    output logic [3:0]  note_off,
    output logic [27:0] voice_note,
    output logic [3:0]  voice_active,
    output logic        stolen,
    output logic        dropped
);
    typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_WAIT_FREE} state_t;
    typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_t;

    state_t     r_state, w_next;
    vstate_t    r_vs    [4];
    logic [1:0] r_rank  [4];
    logic [6:0] r_vnote [4];
    logic       r_pend_on;
    logic [6:0] r_pend_note;
    logic [3:0] r_note_on, r_note_off;
    logic       r_stolen, r_dropped;

    logic [3:0] w_eff_free, w_held, w_rel, w_match;
    logic [1:0] w_free_idx, w_match_idx, w_steal_idx, w_best, w_rel_idx;
    logic       w_found;
    logic       w_alloc, w_release, w_steal, w_drop;

    assign ev_ready = (r_state == S_IDLE);
    assign note_on  = r_note_on;
    assign note_off = r_note_off;
    assign stolen   = r_stolen;
    assign dropped  = r_dropped;

    always_comb begin
        w_eff_free   = '0;
        w_held       = '0;
        w_rel        = '0;
        w_match      = '0;
        voice_active = '0;
        voice_note   = '0;
        for (int i = 0; i < 4; i++) begin
            w_held[i]       = (r_vs[i] == V_HELD);
            w_rel[i]        = (r_vs[i] == V_REL);
            w_eff_free[i]   = (r_vs[i] == V_FREE) | (w_rel[i] & voice_done[i]);
            w_match[i]      = w_held[i] & (r_vnote[i] == r_pend_note);
            voice_active[i] = (r_vs[i] != V_FREE);
            voice_note[7*i +: 7] = r_vnote[i];
        end
    end

    // Descending scans so the last hit is the lowest index; steal scan keeps the oldest held voice.
    always_comb begin
        w_free_idx  = 2'd0;
        w_match_idx = 2'd0;
        w_steal_idx = 2'd0;
        w_best      = 2'd0;
        w_found     = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (w_eff_free[i]) w_free_idx  = 2'(i);
            if (w_match[i])    w_match_idx = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (w_held[i] && (!w_found || r_rank[i] > w_best)) begin
                w_steal_idx = 2'(i);
                w_best      = r_rank[i];
                w_found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_alloc   = 1'b0;
        w_release = 1'b0;
        w_steal   = 1'b0;
        w_drop    = 1'b0;
        w_rel_idx = r_pend_on ? w_steal_idx : w_match_idx;
        case (r_state)
            S_IDLE: begin
                if (ev_valid) w_next = S_DECIDE;
            end
            S_DECIDE: begin
                w_next = S_IDLE;
                if (!r_pend_on) begin
                    if (|w_match) w_release = 1'b1;
                    else          w_drop    = 1'b1;
                end else if (|w_match) begin
                    w_drop = 1'b1;
                end else if (|w_eff_free) begin
                    w_alloc = 1'b1;
                end else if (|w_rel) begin
                    w_next = S_WAIT_FREE;
                end else begin
                    w_release = 1'b1;
                    w_steal   = 1'b1;
                    w_next    = S_WAIT_FREE;
                end
            end
            S_WAIT_FREE: begin
                if (|(w_rel & voice_done)) w_next = S_DECIDE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_on   <= 1'b0;
            r_pend_note <= '0;
            r_note_on   <= '0;
            r_note_off  <= '0;
            r_stolen    <= 1'b0;
            r_dropped   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_vs[i]    <= V_FREE;
                r_rank[i]  <= 2'(i);
                r_vnote[i] <= '0;
            end
        end else begin
            r_note_on  <= '0;
            r_note_off <= '0;
            r_stolen   <= 1'b0;
            r_dropped  <= w_drop;
            if (ev_valid && ev_ready) begin
                r_pend_on   <= ev_on;
                r_pend_note <= ev_note;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_rel[i] && voice_done[i]) r_vs[i] <= V_FREE;
            end
            if (w_release) begin
                r_vs[w_rel_idx]       <= V_REL;
                r_note_off[w_rel_idx] <= 1'b1;
                r_stolen              <= w_steal;
            end
            // Allocation wins over the same-cycle free of the chosen voice.
            if (w_alloc) begin
                r_vs[w_free_idx]      <= V_HELD;
                r_vnote[w_free_idx]   <= r_pend_note;
                r_note_on[w_free_idx] <= 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (i == int'(w_free_idx))
                        r_rank[i] <= 2'd0;
                    else if (r_rank[i] < r_rank[w_free_idx])
                        r_rank[i] <= r_rank[i] + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator
module tb_voice_allocator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic        ev_on = 1'b0;
    logic [6:0]  ev_note = '0;
    logic [3:0]  voice_done = '0;
    logic [3:0]  note_on, note_off;
    logic [27:0] voice_note;
    logic [3:0]  voice_active;
    logic        stolen, dropped;

    voice_allocator dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .voice_done(voice_done),
        .note_on(note_on), .note_off(note_off), .voice_note(voice_note),
        .voice_active(voice_active), .stolen(stolen), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Pulse pattern: {note_on[3:0], note_off[3:0], stolen, dropped}
    typedef struct {
        int         cyc;
        logic [9:0] pat;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [9:0] obs;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            obs = {note_on, note_off, stolen, dropped};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                e = q.pop_front();
                $display("FAIL pulse_missing cyc=%0d required pattern %b never seen", e.cyc, e.pat);
            end
            if (obs !== 10'b0 || (q.size() > 0 && q[0].cyc == cyc)) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL pulse_unexpected cyc=%0d got %b required none", cyc, obs);
                end else begin
                    e = q.pop_front();
                    if (e.cyc !== cyc || e.pat !== obs)
                        $display("FAIL pulse cyc=%0d got %b required %b at cyc %0d", cyc, obs, e.pat, e.cyc);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
    endtask

    task automatic send(input logic on, input logic [6:0] note, input logic [9:0] pat);
        int n;
        n = 0;
        @(negedge clk);
        while (ev_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ev_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout ev_ready=%b required 1", ev_ready);
        end else begin
            ev_valid = 1'b1;
            ev_on    = on;
            ev_note  = note;
            @(posedge clk);
            #1 ev_valid = 1'b0;
            if (pat != 10'b0) q.push_back('{cyc + 1, pat});
        end
    endtask

    task automatic done_pulse(input logic [3:0] v, input logic [9:0] pat);
        @(negedge clk);
        voice_done = v;
        @(posedge clk);
        #1 voice_done = 4'b0;
        if (pat != 10'b0) q.push_back('{cyc + 1, pat});
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL reset_ev_ready got %b required 1", ev_ready); else n_pass++;
        n_checks++; if (voice_active !== 4'b0) $display("FAIL reset_active got %b required 0000", voice_active); else n_pass++;
        n_checks++; if (voice_note !== 28'b0) $display("FAIL reset_note got %h required 0", voice_note); else n_pass++;
        n_checks++;
        if ({note_on, note_off, stolen, dropped} !== 10'b0)
            $display("FAIL reset_pulses got %b required 0", {note_on, note_off, stolen, dropped});
        else n_pass++;
    endtask

    task automatic test_alloc();
        do_reset();
        send(1'b1, 7'd60, {4'b0001, 4'b0, 2'b0});
        send(1'b1, 7'd62, {4'b0010, 4'b0, 2'b0});
        send(1'b1, 7'd64, {4'b0100, 4'b0, 2'b0});
        repeat (4) @(negedge clk);
        n_checks++; if (voice_note[6:0] !== 7'd60) $display("FAIL alloc_note0 got %0d required 60", voice_note[6:0]); else n_pass++;
        n_checks++; if (voice_note[13:7] !== 7'd62) $display("FAIL alloc_note1 got %0d required 62", voice_note[13:7]); else n_pass++;
        n_checks++; if (voice_note[20:14] !== 7'd64) $display("FAIL alloc_note2 got %0d required 64", voice_note[20:14]); else n_pass++;
        n_checks++; if (voice_active !== 4'b0111) $display("FAIL alloc_active got %b required 0111", voice_active); else n_pass++;
        n_checks++; if (q.size() != 0) $display("FAIL alloc_pending got %0d required 0", q.size()); else n_pass++;
    endtask

    task automatic test_steal();
        do_reset();
        send(1'b1, 7'd60, {4'b0001, 4'b0, 2'b0});
        send(1'b1, 7'd62, {4'b0010, 4'b0, 2'b0});
        send(1'b1, 7'd64, {4'b0100, 4'b0, 2'b0});
        send(1'b1, 7'd65, {4'b1000, 4'b0, 2'b0});
        send(1'b1, 7'd67, {4'b0000, 4'b0001, 2'b10});
        repeat (10) @(negedge clk);
        n_checks++; if (ev_ready !== 1'b0) $display("FAIL steal_waiting ev_ready got %b required 0", ev_ready); else n_pass++;
        n_checks++; if (voice_active !== 4'b1111) $display("FAIL steal_active got %b required 1111", voice_active); else n_pass++;
        done_pulse(4'b0001, {4'b0001, 4'b0, 2'b0});
        repeat (4) @(negedge clk);
        n_checks++; if (voice_note[6:0] !== 7'd67) $display("FAIL steal_note0 got %0d required 67", voice_note[6:0]); else n_pass++;
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL steal_ready got %b required 1", ev_ready); else n_pass++;
        n_checks++; if (q.size() != 0) $display("FAIL steal_pending got %0d required 0", q.size()); else n_pass++;
    endtask

    task automatic test_release();
        do_reset();
        send(1'b1, 7'd60, {4'b0001, 4'b0, 2'b0});
        send(1'b1, 7'd62, {4'b0010, 4'b0, 2'b0});
        send(1'b1, 7'd64, {4'b0100, 4'b0, 2'b0});
        send(1'b0, 7'd62, {4'b0000, 4'b0010, 2'b00});
        repeat (3) @(negedge clk);
        n_checks++; if (voice_active !== 4'b0111) $display("FAIL rel_active got %b required 0111", voice_active); else n_pass++;
        done_pulse(4'b0010, 10'b0);
        @(negedge clk);
        n_checks++; if (voice_active !== 4'b0101) $display("FAIL rel_freed got %b required 0101", voice_active); else n_pass++;
        n_checks++; if (voice_note[13:7] !== 7'd62) $display("FAIL rel_note_kept got %0d required 62", voice_note[13:7]); else n_pass++;
        send(1'b0, 7'd62, {4'b0000, 4'b0000, 2'b01});
        repeat (4) @(negedge clk);
        n_checks++; if (q.size() != 0) $display("FAIL rel_pending got %0d required 0", q.size()); else n_pass++;
    endtask

    task automatic test_decide_free();
        do_reset();
        send(1'b1, 7'd60, {4'b0001, 4'b0, 2'b0});
        send(1'b1, 7'd62, {4'b0010, 4'b0, 2'b0});
        send(1'b1, 7'd64, {4'b0100, 4'b0, 2'b0});
        send(1'b1, 7'd65, {4'b1000, 4'b0, 2'b0});
        send(1'b0, 7'd60, {4'b0000, 4'b0001, 2'b00});
        send(1'b0, 7'd62, {4'b0000, 4'b0010, 2'b00});
        send(1'b0, 7'd64, {4'b0000, 4'b0100, 2'b00});
        send(1'b0, 7'd65, {4'b0000, 4'b1000, 2'b00});
        send(1'b1, 7'd70, {4'b0100, 4'b0, 2'b0});
        voice_done = 4'b0100;
        @(posedge clk);
        #1 voice_done = 4'b0;
        @(negedge clk);
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL direct_ready got %b required 1", ev_ready); else n_pass++;
        n_checks++; if (voice_note[20:14] !== 7'd70) $display("FAIL direct_note2 got %0d required 70", voice_note[20:14]); else n_pass++;
        n_checks++; if (voice_active !== 4'b1111) $display("FAIL direct_active got %b required 1111", voice_active); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (q.size() != 0) $display("FAIL direct_pending got %0d required 0", q.size()); else n_pass++;
    endtask

    task automatic test_duplicate();
        do_reset();
        send(1'b1, 7'd60, {4'b0001, 4'b0, 2'b0});
        send(1'b1, 7'd60, {4'b0000, 4'b0000, 2'b01});
        repeat (4) @(negedge clk);
        n_checks++; if (voice_active !== 4'b0001) $display("FAIL dup_active got %b required 0001", voice_active); else n_pass++;
        n_checks++; if (q.size() != 0) $display("FAIL dup_pending got %0d required 0", q.size()); else n_pass++;
    endtask

    task automatic test_reset_wait();
        do_reset();
        send(1'b1, 7'd60, {4'b0001, 4'b0, 2'b0});
        send(1'b1, 7'd62, {4'b0010, 4'b0, 2'b0});
        send(1'b1, 7'd64, {4'b0100, 4'b0, 2'b0});
        send(1'b1, 7'd65, {4'b1000, 4'b0, 2'b0});
        send(1'b1, 7'd67, {4'b0000, 4'b0001, 2'b10});
        repeat (3) @(negedge clk);
        n_checks++; if (q.size() != 0) $display("FAIL rw_pending got %0d required 0", q.size()); else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ev_ready !== 1'b1) $display("FAIL rw_ready got %b required 1", ev_ready); else n_pass++;
        n_checks++; if (voice_active !== 4'b0) $display("FAIL rw_active got %b required 0000", voice_active); else n_pass++;
        n_checks++;
        if ({note_on, note_off, stolen, dropped} !== 10'b0)
            $display("FAIL rw_pulses got %b required 0", {note_on, note_off, stolen, dropped});
        else n_pass++;
        done_pulse(4'b0001, 10'b0);
        repeat (5) @(negedge clk);
        n_checks++; if (voice_active !== 4'b0) $display("FAIL rw_lost got %b required 0000", voice_active); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alloc();
        test_steal();
        test_release();
        test_decide_free();
        test_duplicate();
        test_reset_wait();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
